// File: rtl/divider_array_sched.sv
// Round-robin scheduler sharing one combinational 16/8 array divider between two requesters.
// Optional DIV_SCHED_GUARD_EN: divide-by-zero/overflow operations bypass the array and return q=FF, r=00.
module divider_array_sched #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_n,
  input  logic [7:0]  req0_d,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_n,
  input  logic [7:0]  req1_d,
  output logic [15:0] div_n,
  output logic [7:0]  div_d,
  input  logic [7:0]  div_q,
  input  logic [7:0]  div_r,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [7:0]  resp_q,
  output logic [7:0]  resp_r,
  output logic        resp_dz,
  output logic        resp_ovf
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          prio;      // 1: req1 wins the next tie
  logic          grant0, grant1;
  logic [15:0]   sel_n;
  logic [7:0]    sel_d;
  logic          sel_dz, sel_ovf;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = !prio;
        grant1 = prio;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  // Readys are forced low while reset is held so every output reads 0 during reset.
  assign req0_ready = grant0 && !rst;
  assign req1_ready = grant1 && !rst;

  assign sel_n   = grant1 ? req1_n : req0_n;
  assign sel_d   = grant1 ? req1_d : req0_d;
  assign sel_dz  = (sel_d == 8'h00);
  assign sel_ovf = !sel_dz && (sel_n[15:8] >= sel_d);

  // NOTE: sequential state uses non-blocking assignments only; the async reset
  // clears every register here since there is no memory array to leave uninitialised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      prio       <= 1'b0;
      div_n      <= '0;
      div_d      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_q     <= '0;
      resp_r     <= '0;
      resp_dz    <= 1'b0;
      resp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            prio     <= grant0;
            resp_id  <= grant1;
            resp_dz  <= sel_dz;
            resp_ovf <= sel_ovf;
`ifdef DIV_SCHED_GUARD_EN
            if (sel_dz || sel_ovf) begin
              // Array operands stay untouched; the result is known without it.
              resp_q     <= 8'hFF;
              resp_r     <= 8'h00;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              div_n <= sel_n;
              div_d <= sel_d;
              cnt   <= CW'(SETTLE_CYCLES - 1);
              state <= SETTLE;
            end
`else
            div_n <= sel_n;
            div_d <= sel_d;
            cnt   <= CW'(SETTLE_CYCLES - 1);
            state <= SETTLE;
`endif
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            resp_q     <= div_q;
            resp_r     <= div_r;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
